// File: rtl/uart_core.sv
// Full-duplex UART: independent TX and RX engines with per-direction baud dividers,
// configurable width, optional parity, 1/2 stop bits and RX error pulses.
module uart_core #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_out_o,
  input  logic                 rx_in_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rxState_t;

  txState_t             txState_q, txState_d;
  logic [DIV_WIDTH-1:0] txCnt_q, txCnt_d, txDiv_q, txDiv_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic [IDX_W-1:0]     txIdx_q, txIdx_d;
  logic                 txParBit_q, txParBit_d, txParEn_q, txParEn_d, txStop2_q, txStop2_d;

  rxState_t             rxState_q, rxState_d;
  logic [DIV_WIDTH-1:0] rxCnt_q, rxCnt_d, rxDiv_q, rxDiv_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d, rxData_q, rxData_d;
  logic [IDX_W-1:0]     rxIdx_q, rxIdx_d;
  logic                 rxParEn_q, rxParEn_d, rxParOdd_q, rxParOdd_d, rxParBit_q, rxParBit_d;
  logic                 rxValid_q, rxValid_d;
  logic                 rxParErr_q, rxParErr_d, rxFrameErr_q, rxFrameErr_d, rxOverrun_q, rxOverrun_d;
  logic                 rxSync1_q, rxSync2_q, rxPrev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q    <= TX_IDLE;
      txCnt_q      <= '0;
      txDiv_q      <= '0;
      txShift_q    <= '0;
      txIdx_q      <= '0;
      txParBit_q   <= 1'b0;
      txParEn_q    <= 1'b0;
      txStop2_q    <= 1'b0;
      rxState_q    <= RX_IDLE;
      rxCnt_q      <= '0;
      rxDiv_q      <= '0;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      rxIdx_q      <= '0;
      rxParEn_q    <= 1'b0;
      rxParOdd_q   <= 1'b0;
      rxParBit_q   <= 1'b0;
      rxValid_q    <= 1'b0;
      rxParErr_q   <= 1'b0;
      rxFrameErr_q <= 1'b0;
      rxOverrun_q  <= 1'b0;
      rxSync1_q    <= 1'b1;
      rxSync2_q    <= 1'b1;
      rxPrev_q     <= 1'b1;
    end else begin
      txState_q    <= txState_d;
      txCnt_q      <= txCnt_d;
      txDiv_q      <= txDiv_d;
      txShift_q    <= txShift_d;
      txIdx_q      <= txIdx_d;
      txParBit_q   <= txParBit_d;
      txParEn_q    <= txParEn_d;
      txStop2_q    <= txStop2_d;
      rxState_q    <= rxState_d;
      rxCnt_q      <= rxCnt_d;
      rxDiv_q      <= rxDiv_d;
      rxShift_q    <= rxShift_d;
      rxData_q     <= rxData_d;
      rxIdx_q      <= rxIdx_d;
      rxParEn_q    <= rxParEn_d;
      rxParOdd_q   <= rxParOdd_d;
      rxParBit_q   <= rxParBit_d;
      rxValid_q    <= rxValid_d;
      rxParErr_q   <= rxParErr_d;
      rxFrameErr_q <= rxFrameErr_d;
      rxOverrun_q  <= rxOverrun_d;
      rxSync1_q    <= rx_in_i;
      rxSync2_q    <= rxSync1_q;
      rxPrev_q     <= rxSync2_q;
    end
  end

  // TX: divider reloads at accept and every bit boundary, so each bit lasts baud_div+1 cycles.
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txDiv_d    = txDiv_q;
    txShift_d  = txShift_q;
    txIdx_d    = txIdx_q;
    txParBit_d = txParBit_q;
    txParEn_d  = txParEn_q;
    txStop2_d  = txStop2_q;
    if (txState_q == TX_IDLE) begin
      if (tx_valid_i) begin
        txState_d  = TX_START;
        txCnt_d    = baud_div_i;
        txDiv_d    = baud_div_i;
        txShift_d  = tx_data_i;
        txParBit_d = (^tx_data_i) ^ parity_odd_i;
        txParEn_d  = parity_en_i;
        txStop2_d  = stop2_i;
        txIdx_d    = '0;
      end
    end else if (txCnt_q != '0) begin
      txCnt_d = txCnt_q - 1'b1;
    end else begin
      txCnt_d = txDiv_q;
      case (txState_q)
        TX_START: begin
          txState_d = TX_DATA;
          txIdx_d   = '0;
        end
        TX_DATA: begin
          txShift_d = txShift_q >> 1;
          if (txIdx_q == LAST_IDX) begin
            txState_d = txParEn_q ? TX_PARITY : TX_STOP;
            txIdx_d   = '0;
          end else begin
            txIdx_d = txIdx_q + 1'b1;
          end
        end
        TX_PARITY: begin
          txState_d = TX_STOP;
          txIdx_d   = '0;
        end
        default: begin
          if (txStop2_q && txIdx_q == '0) begin
            txIdx_d = txIdx_q + 1'b1;
          end else begin
            txState_d = TX_IDLE;
            txCnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    case (txState_q)
      TX_START:  tx_out_o = 1'b0;
      TX_DATA:   tx_out_o = txShift_q[0];
      TX_PARITY: tx_out_o = txParBit_q;
      default:   tx_out_o = 1'b1;
    endcase
  end

  // RX: half-period preload on the start edge puts every later divider expiry mid-bit.
  always_comb begin
    rxState_d    = rxState_q;
    rxCnt_d      = rxCnt_q;
    rxDiv_d      = rxDiv_q;
    rxShift_d    = rxShift_q;
    rxData_d     = rxData_q;
    rxIdx_d      = rxIdx_q;
    rxParEn_d    = rxParEn_q;
    rxParOdd_d   = rxParOdd_q;
    rxParBit_d   = rxParBit_q;
    rxValid_d    = rxValid_q & ~rx_ready_i;
    rxParErr_d   = 1'b0;
    rxFrameErr_d = 1'b0;
    rxOverrun_d  = 1'b0;
    if (rxState_q == RX_IDLE) begin
      if (rxPrev_q && !rxSync2_q) begin
        rxState_d  = RX_START;
        rxCnt_d    = baud_div_i >> 1;
        rxDiv_d    = baud_div_i;
        rxParEn_d  = parity_en_i;
        rxParOdd_d = parity_odd_i;
        rxIdx_d    = '0;
      end
    end else if (rxState_q == RX_BREAK) begin
      if (rxSync2_q) rxState_d = RX_IDLE;
    end else if (rxCnt_q != '0) begin
      rxCnt_d = rxCnt_q - 1'b1;
    end else begin
      rxCnt_d = rxDiv_q;
      case (rxState_q)
        RX_START: begin
          rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
          rxIdx_d   = '0;
        end
        RX_DATA: begin
          rxShift_d = {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
          if (rxIdx_q == LAST_IDX) begin
            rxState_d = rxParEn_q ? RX_PARITY : RX_STOP;
          end else begin
            rxIdx_d = rxIdx_q + 1'b1;
          end
        end
        RX_PARITY: begin
          rxParBit_d = rxSync2_q;
          rxState_d  = RX_STOP;
        end
        default: begin
          rxState_d = RX_IDLE;
          rxCnt_d   = '0;
          if (!rxSync2_q) begin
            rxFrameErr_d = 1'b1;
            if (rxShift_q == '0) rxState_d = RX_BREAK;
          end else if (rxParEn_q && (rxParBit_q != ((^rxShift_q) ^ rxParOdd_q))) begin
            rxParErr_d = 1'b1;
          end else if (rxValid_q && !rx_ready_i) begin
            rxOverrun_d = 1'b1;
          end else begin
            rxData_d  = rxShift_q;
            rxValid_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign tx_ready_o      = (txState_q == TX_IDLE);
  assign rx_data_o       = rxData_q;
  assign rx_valid_o      = rxValid_q;
  assign rx_parity_err_o = rxParErr_q;
  assign rx_frame_err_o  = rxFrameErr_q;
  assign rx_overrun_o    = rxOverrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected TX line levels, RX words
// and RX error kinds into queues; a negedge monitor pops and compares them.
module tb_uart_core;

  localparam int DB = 8;
  localparam int DW = 16;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_FRAME   = 2;
  localparam int ERR_OVERRUN = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] baudDiv;
  logic          parityEn, parityOdd, stop2;
  logic [DB-1:0] txData;
  logic          txValid, txReady, txOut;
  logic          rxLine, loopback;
  logic          rxIn;
  logic [DB-1:0] rxData;
  logic          rxValid, rxReady;
  logic          rxParityErr, rxFrameErr, rxOverrun;

  int testsRun = 0;
  int testsFailed = 0;

  logic          expTxQ[$];
  logic [DB-1:0] expRxQ[$];
  int            expErrQ[$];
  logic          monTx;
  logic [DB-1:0] monRx;

  assign rxIn = loopback ? txOut : rxLine;

  uart_core #(.DATA_BITS(DB), .DIV_WIDTH(DW)) dut (
    .clk(clk),
    .reset(reset),
    .baud_div_i(baudDiv),
    .parity_en_i(parityEn),
    .parity_odd_i(parityOdd),
    .stop2_i(stop2),
    .tx_data_i(txData),
    .tx_valid_i(txValid),
    .tx_ready_o(txReady),
    .tx_out_o(txOut),
    .rx_in_i(rxIn),
    .rx_data_o(rxData),
    .rx_valid_o(rxValid),
    .rx_ready_i(rxReady),
    .rx_parity_err_o(rxParityErr),
    .rx_frame_err_o(rxFrameErr),
    .rx_overrun_o(rxOverrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkErr(input int code);
    int e;
    if (expErrQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL rx_err_unexpected: pulse kind %0d, none expected", code);
    end else begin
      e = expErrQ.pop_front();
      checkOutput("rx_err_kind", code, e);
    end
  endtask

  // Monitor: TX line is checked every busy cycle, RX words at each handshake, errors per pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (!txReady) begin
        if (expTxQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL tx_busy: tx_ready low with no expected line level (tx_out=%0b)", txOut);
        end else begin
          monTx = expTxQ.pop_front();
          checkOutput("tx_out", {31'b0, txOut}, {31'b0, monTx});
        end
      end
      if (rxValid && rxReady) begin
        if (expRxQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL rx_unexpected: word 0x%0h, none expected", rxData);
        end else begin
          monRx = expRxQ.pop_front();
          checkOutput("rx_data", {24'b0, rxData}, {24'b0, monRx});
        end
      end
      if (rxParityErr) checkErr(ERR_PARITY);
      if (rxFrameErr)  checkErr(ERR_FRAME);
      if (rxOverrun)   checkErr(ERR_OVERRUN);
    end
  end

  task automatic pushLevel(input logic level);
    for (int c = 0; c <= int'(baudDiv); c++) expTxQ.push_back(level);
  endtask

  task automatic pushTxFrame(input logic [DB-1:0] d);
    pushLevel(1'b0);
    for (int i = 0; i < DB; i++) pushLevel(d[i]);
    if (parityEn) pushLevel((^d) ^ parityOdd);
    pushLevel(1'b1);
    if (stop2) pushLevel(1'b1);
  endtask

  // Present a TX word and return one cycle after it is accepted (at posedge+1).
  task automatic applyStimulus(input logic [DB-1:0] d, input bit pushTx, input bit pushRx);
    int n;
    txData = d;
    txValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!txReady && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!txReady) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL tx_accept_timeout: tx_ready=%0b, required 1", txReady);
    end
    if (pushTx) pushTxFrame(d);
    if (pushRx) expRxQ.push_back(d);
    @(posedge clk);
    #1 txValid = 1'b0;
  endtask

  task automatic waitTxIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!txReady && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!txReady) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL tx_idle_timeout: tx_ready=%0b, required 1", txReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic driveBit(input logic level);
    rxLine = level;
    repeat (int'(baudDiv) + 1) @(posedge clk);
    #1;
  endtask

  task automatic driveFrame(input logic [DB-1:0] d, input bit withPar, input logic parBit);
    driveBit(1'b0);
    for (int i = 0; i < DB; i++) driveBit(d[i]);
    if (withPar) driveBit(parBit);
    driveBit(1'b1);
    driveBit(1'b1);
  endtask

  initial begin
    logic seqA5 [10];
    seqA5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b1;
    baudDiv = 16'd3;
    parityEn = 1'b0;
    parityOdd = 1'b0;
    stop2 = 1'b0;
    txData = '0;
    txValid = 1'b0;
    rxLine = 1'b1;
    loopback = 1'b0;
    rxReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_tx_out", {31'b0, txOut}, 32'd1);
    checkOutput("reset_tx_ready", {31'b0, txReady}, 32'd1);
    checkOutput("reset_rx_valid", {31'b0, rxValid}, 32'd0);
    checkOutput("reset_rx_data", {24'b0, rxData}, 32'd0);
    checkOutput("reset_errors", {29'b0, rxParityErr, rxFrameErr, rxOverrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] 8-N-1 transmit of 0xA5, baud_div=3");
    for (int b = 0; b < 10; b++) pushLevel(seqA5[b]);
    applyStimulus(8'hA5, 1'b0, 1'b0);
    waitTxIdle();
    checkOutput("a5_frame_length", expTxQ.size(), 32'd0);

    $display("[TB] loopback 0x00..0xFF, odd parity, 2 stop bits");
    parityEn = 1'b1;
    parityOdd = 1'b1;
    stop2 = 1'b1;
    loopback = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int v = 0; v < 256; v++) applyStimulus(v[DB-1:0], 1'b1, 1'b1);
    waitTxIdle();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("loop_tx_drained", expTxQ.size(), 32'd0);
    checkOutput("loop_rx_drained", expRxQ.size(), 32'd0);

    $display("[TB] 0x3C with wrong even parity");
    loopback = 1'b0;
    parityOdd = 1'b0;
    stop2 = 1'b0;
    expErrQ.push_back(ERR_PARITY);
    driveFrame(8'h3C, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("parity_err_seen", expErrQ.size(), 32'd0);
    checkOutput("parity_no_valid", {31'b0, rxValid}, 32'd0);

    $display("[TB] overrun: 0x11 then 0x22 with rx_ready low");
    parityEn = 1'b0;
    rxReady = 1'b0;
    expRxQ.push_back(8'h11);
    expErrQ.push_back(ERR_OVERRUN);
    driveFrame(8'h11, 1'b0, 1'b0);
    driveFrame(8'h22, 1'b0, 1'b0);
    checkOutput("overrun_held_valid", {31'b0, rxValid}, 32'd1);
    checkOutput("overrun_held_data", {24'b0, rxData}, 32'h11);
    checkOutput("overrun_pulse_seen", expErrQ.size(), 32'd0);
    rxReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("overrun_popped", expRxQ.size(), 32'd0);
    checkOutput("overrun_valid_cleared", {31'b0, rxValid}, 32'd0);

    $display("[TB] break: line low for 3 frame times, then 0x55");
    expErrQ.push_back(ERR_FRAME);
    rxLine = 1'b0;
    repeat (3 * 10 * 4) @(posedge clk);
    #1 rxLine = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("break_frame_err", expErrQ.size(), 32'd0);
    expRxQ.push_back(8'h55);
    driveFrame(8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("break_recovery", expRxQ.size(), 32'd0);

    $display("[TB] 2-cycle glitch with baud_div=7, then 0x5A");
    baudDiv = 16'd7;
    rxLine = 1'b0;
    repeat (2) @(posedge clk);
    #1 rxLine = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("glitch_no_valid", {31'b0, rxValid}, 32'd0);
    expRxQ.push_back(8'h5A);
    driveFrame(8'h5A, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("glitch_recovery", expRxQ.size(), 32'd0);

    $display("[TB] asynchronous reset in the middle of a loopback frame");
    baudDiv = 16'd3;
    loopback = 1'b1;
    applyStimulus(8'hC3, 1'b1, 1'b1);
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("midreset_tx_out", {31'b0, txOut}, 32'd1);
    checkOutput("midreset_tx_ready", {31'b0, txReady}, 32'd1);
    expTxQ.delete();
    expRxQ.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("midreset_rx_discard", {31'b0, rxValid}, 32'd0);
    applyStimulus(8'h3E, 1'b1, 1'b1);
    waitTxIdle();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_tx_drained", expTxQ.size(), 32'd0);
    checkOutput("final_rx_drained", expRxQ.size(), 32'd0);
    checkOutput("final_err_drained", expErrQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
